sc_core_oz_rf_dump: RTL

//  Debug reader on the sc_core_oz register file read port. On request it halts the core and

---
 rtl/sc_core_oz_rf_dump.sv | 104 ++++++++++
 1 files changed

// File: rtl/sc_core_oz_rf_dump.sv
// Debug register-file dumper for sc_core_oz.
// On DumpReq it halts the core, then reads x0..x(NUM_REGS-1) through the RF read port one index
// at a time. Each value is streamed out as {DumpIdx, DumpData} over a valid/ready handshake. The
// core is released after a one-cycle DumpDone pulse.
// Ports:
//   clk, rst        core clock, asynchronous active-high reset
//   DumpReq         start a dump (sampled only when idle)
//   DumpAbort       end the dump early (ignored when idle or done)
//   CoreHalt        core must freeze its PC and suppress RF writes
//   RfRdIdx         RF read address (muxed onto RegSrc1 by the core while halted)
//   RfRdData        combinational RF read data for RfRdIdx
//   DumpValid/Ready beat handshake; DumpIdx/DumpData hold the beat
//   DumpDone        one-cycle pulse at the end of a dump, including an aborted one
module sc_core_oz_rf_dump #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DumpReq,
  input  logic              DumpAbort,
  output logic              CoreHalt,
  output logic [IDX_W-1:0]  RfRdIdx,
  input  logic [DATA_W-1:0] RfRdData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [IDX_W-1:0]  DumpIdx,
  output logic [DATA_W-1:0] DumpData,
  output logic              DumpDone
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StHalt, StRead, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_idx_q  <= dump_idx_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_idx_d  = dump_idx_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      // A simultaneous abort is ignored here: the request wins.
      StIdle: if (DumpReq) state_d = StHalt;
      // Drain cycle: lets an in-flight core write land before the first read.
      StHalt: begin
        idx_d   = '0;
        state_d = DumpAbort ? StDone : StRead;
      end
      StRead: begin
        if (DumpAbort) begin
          state_d = StDone;
        end else begin
          dump_idx_d  = idx_q;
          dump_data_d = RfRdData;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (DumpReady) begin
          // An abort coinciding with a handshake still delivers this beat.
          if (DumpAbort || idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StRead;
          end
        end else if (DumpAbort) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decoded from state so reset clears them asynchronously.
  assign CoreHalt  = (state_q != StIdle);
  assign DumpValid = (state_q == StSend);
  assign DumpDone  = (state_q == StDone);
  assign RfRdIdx   = (state_q == StRead) ? idx_q : '0;
  assign DumpIdx   = dump_idx_q;
  assign DumpData  = dump_data_q;

endmodule
